// File: rtl/div_unit_pkg.sv
// Shared constants for the divider. EX uses the same constants to drive start_i
// and to gate its stall request on ready_o.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU. Produces one quotient bit per clock
// and returns {remainder, quotient} for HI/LO.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    div_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   divisor;
    logic                neg_q;
    logic                neg_r;

    logic [DATA_W:0]     shifted;
    logic [DATA_W+1:0]   diff;
    logic                borrow;
    logic [DATA_W-1:0]   rem_nxt;
    logic [DATA_W-1:0]   quo_nxt;
    logic [DATA_W-1:0]   q_fix;
    logic [DATA_W-1:0]   r_fix;
    logic                a_neg;
    logic                b_neg;

    // Trial subtract over one extra bit so the borrow is visible even when the
    // shifted partial remainder needs DATA_W+1 bits.
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        borrow  = diff[DATA_W+1];
        rem_nxt = borrow ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
        quo_nxt = {quo[DATA_W-2:0], ~borrow};
        q_fix   = neg_q ? (~quo + 1'b1) : quo;
        r_fix   = neg_r ? (~rem + 1'b1) : rem;
        a_neg   = signed_div_i & opdata1_i[DATA_W-1];
        b_neg   = signed_div_i & opdata2_i[DATA_W-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DivFree;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    if (start_i == DivStart && !annul_i) begin
                        cnt     <= '0;
                        rem     <= '0;
                        quo     <= a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
                        divisor <= b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        state   <= (opdata2_i == '0) ? DivByZero : DivOn;
                    end
                end
                DivByZero: begin
                    result_o <= '0;
                    ready_o  <= DivResultReady;
                    state    <= DivEnd;
                end
                DivOn: begin
                    if (annul_i) begin
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                        state    <= DivFree;
                    end else if (cnt == CNT_W'(DATA_W)) begin
                        result_o <= {r_fix, q_fix};
                        ready_o  <= DivResultReady;
                        state    <= DivEnd;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                        state    <= DivFree;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit: a driver issues divisions and queues
// the expected {remainder, quotient} and latency; a monitor checks each ready rise.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic ready_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division, truncating toward zero; /0 yields 0.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && ready_o && !ready_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got result %h with no request pending", result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result_o, e.res);
                check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
            end
        end
        ready_q <= ready_o;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
        exp_t e;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        if (push) begin
            e.res       = model(a, b, s);
            e.lat       = (b == 32'h0) ? 1 : 33;
            e.start_cyc = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
        logic [63:0] exp_res;
        bit          got;
        exp_res = model(a, b, s);
        issue(a, b, s, 1'b1);
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            // Operands are don't-care once latched.
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~s;
            if (ready_o) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: ready_o=%b expected 1 within 60 cycles", ready_o);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_ready", 64'(ready_o), 64'd1);
            check("hold_result", result_o, exp_res);
        end
        start_i = 1'b0;
        @(negedge clk);
        check("drop_ready", 64'(ready_o), 64'd0);
        check("drop_result", result_o, 64'h0);
    endtask

    initial begin
        logic [31:0] a, b;
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, 2);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1);
        run_op(32'd5, 32'd0, 1'b0, 1);
        run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);

        // Annul partway through the iteration: nothing must be reported.
        issue(32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_ready", 64'(ready_o), 64'd0);
        run_op(32'd100, 32'd10, 1'b0, 0);

        // start with annul held is ignored entirely.
        @(negedge clk);
        start_i = 1'b1;
        annul_i = 1'b1;
        repeat (40) @(negedge clk);
        check("start_annul_ready", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;

        // Asynchronous reset mid-iteration.
        issue(32'd12345, 32'd17, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_ready", 64'(ready_o), 64'd0);
        check("rst_mid_result", result_o, 64'h0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op(32'd9, 32'd3, 1'b0, 0);

        // Asynchronous reset while a result is presented clears it without a clock.
        issue(32'd77, 32'd5, 1'b0, 1'b1);
        repeat (36) @(negedge clk);
        check("end_ready", 64'(ready_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_end_ready", 64'(ready_o), 64'd0);
        check("rst_end_result", result_o, 64'h0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 20);
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'(0 - $urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
